// File: rtl/ste_audio_pkg.sv
// Shared definitions for the STE LMC1992 emulation: command codes, reset
// values, the attenuation gain ROM and the output saturation helper.
package ste_audio_pkg;

  localparam int         MW_BITS  = 11;
  localparam logic [1:0] LMC_ADDR = 2'b10;

  localparam logic [2:0] CMD_MIX    = 3'b000;
  localparam logic [2:0] CMD_BASS   = 3'b001;
  localparam logic [2:0] CMD_TREBLE = 3'b010;
  localparam logic [2:0] CMD_MASTER = 3'b011;
  localparam logic [2:0] CMD_RIGHT  = 3'b100;
  localparam logic [2:0] CMD_LEFT   = 3'b101;

  localparam logic [5:0] RST_MASTER = 6'd40;
  localparam logic [4:0] RST_SIDE   = 5'd20;
  localparam logic [3:0] RST_TONE   = 4'd6;
  localparam logic [1:0] RST_MIX    = 2'b01;

  // round(256 * 10^(-i/10)); index 40 and above is mute
  function automatic logic [8:0] lmc_gain(input logic [5:0] idx);
    case (idx)
      6'd0:  lmc_gain = 9'd256;
      6'd1:  lmc_gain = 9'd203;
      6'd2:  lmc_gain = 9'd162;
      6'd3:  lmc_gain = 9'd128;
      6'd4:  lmc_gain = 9'd102;
      6'd5:  lmc_gain = 9'd81;
      6'd6:  lmc_gain = 9'd64;
      6'd7:  lmc_gain = 9'd51;
      6'd8:  lmc_gain = 9'd41;
      6'd9:  lmc_gain = 9'd32;
      6'd10: lmc_gain = 9'd26;
      6'd11: lmc_gain = 9'd20;
      6'd12: lmc_gain = 9'd16;
      6'd13: lmc_gain = 9'd13;
      6'd14: lmc_gain = 9'd10;
      6'd15: lmc_gain = 9'd8;
      6'd16: lmc_gain = 9'd6;
      6'd17: lmc_gain = 9'd5;
      6'd18: lmc_gain = 9'd4;
      6'd19, 6'd20: lmc_gain = 9'd3;
      6'd21, 6'd22: lmc_gain = 9'd2;
      6'd23, 6'd24, 6'd25, 6'd26, 6'd27: lmc_gain = 9'd1;
      default: lmc_gain = 9'd0;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767)       sat16 = 16'h7FFF;
    else if (v < -19'sd32768) sat16 = 16'h8000;
    else                      sat16 = v[15:0];
  endfunction

endpackage

// File: rtl/lmc1992_mw_rx.sv
// Microwire receiver: collects masked serial bits and validates the frame on
// mw_done. cmd/data/cmd_valid are registered, valid for one cycle.
module lmc1992_mw_rx
  import ste_audio_pkg::*;
(
  input  logic       clk32,
  input  logic       reset,
  input  logic       mw_strobe,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_done,
  output logic [2:0] cmd,
  output logic [5:0] data,
  output logic       cmd_valid
);

  logic [10:0] sr, sr_nxt;
  logic [3:0]  cnt, cnt_nxt;

  // a strobe coinciding with mw_done is shifted before the frame is judged
  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = cnt;
    if (mw_strobe && mw_clk) begin
      sr_nxt = {sr[9:0], mw_data};
      if (cnt != 4'd15) cnt_nxt = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      sr        <= '0;
      cnt       <= '0;
      cmd       <= '0;
      data      <= '0;
      cmd_valid <= 1'b0;
    end else begin
      sr        <= sr_nxt;
      cnt       <= mw_done ? 4'd0 : cnt_nxt;
      cmd_valid <= mw_done && (cnt_nxt == 4'(MW_BITS)) && (sr_nxt[10:9] == LMC_ADDR);
      if (mw_done) begin
        cmd  <= sr_nxt[8:6];
        data <= sr_nxt[5:0];
      end
    end
  end

endmodule

// File: rtl/ste_lmc1992.sv
// STE LMC1992 volume/tone controller: microwire register file plus a
// 2-stage DMA/YM mix and attenuation pipeline per stereo lane.
module ste_lmc1992
  import ste_audio_pkg::*;
(
  input  logic        clk32,
  input  logic        reset,
  input  logic        mw_strobe,
  input  logic        mw_clk,
  input  logic        mw_data,
  input  logic        mw_done,
  input  logic        sample_en,
  input  logic [7:0]  dma_l,
  input  logic [7:0]  dma_r,
  input  logic [7:0]  ym_in,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        out_valid,
  output logic [5:0]  master_vol
);

  localparam int NUM_LANES = 2;
  localparam int STAGES    = 2;

  logic [2:0] cmd;
  logic [5:0] data;
  logic       cmd_valid;

  lmc1992_mw_rx u_rx (
    .clk32, .reset, .mw_strobe, .mw_clk, .mw_data, .mw_done,
    .cmd, .data, .cmd_valid
  );

  logic [5:0] master;
  logic [4:0] left, right;
  logic [3:0] bass, treble;
  logic [1:0] mix;

  always_ff @(posedge clk32) begin
    if (reset) begin
      master <= RST_MASTER;
      left   <= RST_SIDE;
      right  <= RST_SIDE;
      bass   <= RST_TONE;
      treble <= RST_TONE;
      mix    <= RST_MIX;
    end else if (cmd_valid) begin
      case (cmd)
        CMD_MIX:    mix    <= data[1:0];
        CMD_BASS:   bass   <= (data[3:0] > 4'd12) ? 4'd12 : data[3:0];
        CMD_TREBLE: treble <= (data[3:0] > 4'd12) ? 4'd12 : data[3:0];
        CMD_MASTER: master <= (data > 6'd40) ? 6'd40 : data;
        CMD_RIGHT:  right  <= (data[4:0] > 5'd20) ? 5'd20 : data[4:0];
        CMD_LEFT:   left   <= (data[4:0] > 5'd20) ? 5'd20 : data[4:0];
        default: ;
      endcase
    end
  end

  // tone settings are register-visible only; no filter consumes them
  logic unused_tone;
  assign unused_tone = ^{bass, treble};

  assign master_vol = master;

  logic [STAGES:0] vld_pipe;
  assign vld_pipe[0] = sample_en;

  always_ff @(posedge clk32) begin
    if (reset) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign out_valid = vld_pipe[STAGES];

  // offset-128 to two's complement is an MSB flip
  logic [7:0] ym_c;
  logic [9:0] y10;
  assign ym_c = {~ym_in[7], ym_in[6:0]};

  always_comb begin
    case (mix)
      2'b00:   y10 = {{4{ym_c[7]}}, ym_c[7:2]};
      2'b01:   y10 = {{2{ym_c[7]}}, ym_c};
      default: y10 = '0;
    endcase
  end

  logic [NUM_LANES-1:0][7:0]  dma;
  logic [NUM_LANES-1:0][4:0]  side;
  logic [NUM_LANES-1:0][15:0] aud;

  assign dma  = {dma_r, dma_l};
  assign side = {right, left};

  genvar i;
  for (i = 0; i < NUM_LANES; i++) begin : g_lane
    logic        [9:0]  s_nxt;
    logic        [6:0]  att;
    logic        [5:0]  idx;
    logic signed [9:0]  s_q;
    logic        [8:0]  g_q;
    logic signed [18:0] prod;

    assign s_nxt = {{3{~dma[i][7]}}, dma[i][6:0]} + y10;
    assign att   = 7'(6'd40 - master) + 7'(5'd20 - side[i]);
    assign idx   = (att > 7'd40) ? 6'd40 : att[5:0];
    assign prod  = 19'(s_q) * 19'($signed({1'b0, g_q}));

    always_ff @(posedge clk32) begin
      if (reset) begin
        s_q <= '0;
        g_q <= '0;
      end else if (vld_pipe[0]) begin
        s_q <= s_nxt;
        g_q <= lmc_gain(idx);
      end
    end

    always_ff @(posedge clk32) begin
      if (reset)            aud[i] <= '0;
      else if (vld_pipe[1]) aud[i] <= sat16(prod >>> 1);
    end
  end

  assign audio_l = aud[0];
  assign audio_r = aud[1];

endmodule

// File: tb/tb_ste_lmc1992.sv
// Bench for ste_lmc1992: fixed vector table, hand-written microwire corner
// sequences and randomized traffic against a behavioural model.
module tb_ste_lmc1992;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        mw_strobe = 1'b0, mw_clk = 1'b0, mw_data = 1'b0, mw_done = 1'b0;
  logic        sample_en = 1'b0;
  logic [7:0]  dma_l = 8'h80, dma_r = 8'h80, ym_in = 8'h80;
  logic [15:0] audio_l, audio_r;
  logic        out_valid;
  logic [5:0]  master_vol;

  ste_lmc1992 dut (
    .clk32(clk32), .reset(reset), .mw_strobe(mw_strobe), .mw_clk(mw_clk),
    .mw_data(mw_data), .mw_done(mw_done), .sample_en(sample_en),
    .dma_l(dma_l), .dma_r(dma_r), .ym_in(ym_in), .audio_l(audio_l),
    .audio_r(audio_r), .out_valid(out_valid), .master_vol(master_vol)
  );

  always #5 clk32 = ~clk32;

  int total = 0;
  int bad   = 0;

  int m_master, m_left, m_right, m_mix;
  bit mq[$];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk32);
    #1;
  endtask

  task automatic model_reset;
    m_master = 40; m_left = 20; m_right = 20; m_mix = 1;
    mq.delete();
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // a frame counts only if exactly 11 masked-in bits arrived since the last done
  task automatic model_done;
    logic [10:0] f;
    int d;
    if (mq.size() == 11) begin
      for (int k = 0; k < 11; k++) f[10-k] = mq[k];
      d = int'(f[5:0]);
      if (f[10:9] == 2'b10) begin
        case (f[8:6])
          3'd0: m_mix    = d % 4;
          3'd3: m_master = min_i(d, 40);
          3'd4: m_right  = min_i(d % 32, 20);
          3'd5: m_left   = min_i(d % 32, 20);
          default: ;
        endcase
      end
    end
    mq.delete();
  endtask

  function automatic int exp_audio(input int d, input int ym, input int side);
    int y, s, idx, g, v;
    if (m_mix == 0)      y = (ym - 128) >>> 2;
    else if (m_mix == 1) y = ym - 128;
    else                 y = 0;
    s   = d - 128 + y;
    idx = min_i((40 - m_master) + (20 - side), 40);
    g   = (idx >= 40) ? 0 : int'($floor(256.0 * $pow(10.0, -idx / 10.0) + 0.5));
    v   = (s * g) >>> 1;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // 16 slots MSB first, strobe every other cycle; optional reset pulse before slot rst_at
  task automatic send(input logic [15:0] bits, input logic [15:0] mask,
                      input bit done_last, input int rst_at);
    for (int k = 15; k >= 0; k--) begin
      if (rst_at == 15 - k) begin
        reset = 1'b1; tick; reset = 1'b0;
        model_reset;
      end
      mw_strobe = 1'b1; mw_clk = mask[k]; mw_data = bits[k];
      if (mask[k]) mq.push_back(bits[k]);
      if (k == 0 && done_last) mw_done = 1'b1;
      tick;
      mw_strobe = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
      tick;
    end
    if (!done_last) begin
      mw_done = 1'b1; tick; mw_done = 1'b0;
    end
    model_done;
    tick; tick; tick;
  endtask

  task automatic frame(input logic [2:0] cmd, input logic [5:0] d);
    send({5'b0, 2'b10, cmd, d}, 16'h07FF, 1'b0, -1);
  endtask

  task automatic sample(input logic [7:0] dl, input logic [7:0] dr, input logic [7:0] ym,
                        input string name, output int got_l, output int got_r);
    dma_l = dl; dma_r = dr; ym_in = ym; sample_en = 1'b1;
    tick;
    sample_en = 1'b0;
    chk({name, " valid@1"}, int'(out_valid), 0);
    tick;
    chk({name, " valid@2"}, int'(out_valid), 1);
    got_l = int'($signed(audio_l));
    got_r = int'($signed(audio_r));
    tick;
    chk({name, " valid@3"}, int'(out_valid), 0);
  endtask

  typedef struct {
    int         mix;
    int         master;
    logic [7:0] dl, dr, ym;
    int         el, er;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int gl, gr, el, er;
    logic [7:0] a, b, c;
    logic [15:0] bits, mask;

    tbl[0] = '{1, 40, 8'hC0, 8'hC0, 8'h80,   8192,   8192};
    tbl[1] = '{1, 20, 8'hC0, 8'hC0, 8'h80,     96,     96};
    tbl[2] = '{0, 40, 8'h80, 8'h80, 8'hFF,   3968,   3968};
    tbl[3] = '{2, 40, 8'h80, 8'h80, 8'hFF,      0,      0};
    tbl[4] = '{1, 40, 8'hFF, 8'hFF, 8'hFF,  32512,  32512};
    tbl[5] = '{1, 40, 8'h00, 8'h00, 8'h00, -32768, -32768};
    tbl[6] = '{1,  0, 8'hFF, 8'h00, 8'hFF,      0,      0};
    tbl[7] = '{2, 40, 8'hC0, 8'h40, 8'h00,   8192,  -8192};
    tbl[8] = '{0, 40, 8'h80, 8'h80, 8'h00,  -4096,  -4096};

    model_reset;
    tick; tick;
    reset = 1'b0;
    chk("reset audio_l", int'(audio_l), 0);
    chk("reset audio_r", int'(audio_r), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset master_vol", int'(master_vol), 40);

    sample(8'hC0, 8'hC0, 8'h80, "first sample", gl, gr);
    chk("first sample L", gl, 8192);
    chk("first sample R", gr, 8192);

    foreach (tbl[n]) begin
      frame(3'b000, 6'(tbl[n].mix));
      frame(3'b011, 6'(tbl[n].master));
      sample(tbl[n].dl, tbl[n].dr, tbl[n].ym, $sformatf("vec%0d", n), gl, gr);
      chk($sformatf("vec%0d L", n), gl, tbl[n].el);
      chk($sformatf("vec%0d R", n), gr, tbl[n].er);
    end

    frame(3'b000, 6'd1);
    frame(3'b011, 6'd40);
    chk("restore master", int'(master_vol), 40);

    send({6'b0, 2'b10, 3'b011, 5'b01010}, 16'h03FF, 1'b0, -1);
    chk("10-bit frame dropped", int'(master_vol), 40);
    send({5'b0, 2'b01, 3'b011, 6'd20}, 16'h07FF, 1'b0, -1);
    chk("addr 01 dropped", int'(master_vol), 40);
    send({5'b0, 2'b10, 3'b011, 6'd20}, 16'hFFFF, 1'b0, -1);
    chk("16-bit frame dropped", int'(master_vol), 40);
    frame(3'b110, 6'd5);
    chk("cmd 110 ignored", int'(master_vol), 40);

    send({5'b0, 2'b10, 3'b011, 6'd30}, 16'h07FF, 1'b1, -1);
    chk("done with last strobe", int'(master_vol), 30);
    frame(3'b011, 6'd63);
    chk("master clamp", int'(master_vol), 40);

    frame(3'b011, 6'd20);
    chk("master 20", int'(master_vol), 20);
    send({5'b0, 2'b10, 3'b011, 6'd10}, 16'h07FF, 1'b0, 11);
    chk("reset mid-frame master", int'(master_vol), 40);
    sample(8'hC0, 8'hC0, 8'h80, "after reset", gl, gr);
    chk("after reset L", gl, 8192);

    frame(3'b101, 6'd0);
    frame(3'b100, 6'd31);
    sample(8'hC0, 8'hC0, 8'h80, "left0", gl, gr);
    chk("left0 L", gl, 96);
    chk("right clamp R", gr, 8192);
    frame(3'b101, 6'd20);

    // back-to-back samples produce two consecutive valid pulses
    dma_l = 8'hC0; dma_r = 8'hC0; ym_in = 8'h80; sample_en = 1'b1;
    tick;
    dma_l = 8'h40; dma_r = 8'h40;
    chk("b2b valid@1", int'(out_valid), 0);
    tick;
    sample_en = 1'b0;
    chk("b2b valid first", int'(out_valid), 1);
    chk("b2b first L", int'($signed(audio_l)), 8192);
    tick;
    chk("b2b valid second", int'(out_valid), 1);
    chk("b2b second L", int'($signed(audio_l)), -8192);
    tick;
    chk("b2b valid end", int'(out_valid), 0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bits = 16'($urandom());
        bits[10:9] = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b10;
        mask = ($urandom_range(0, 4) == 0) ? 16'($urandom()) : 16'h07FF;
        send(bits, mask, 1'($urandom_range(0, 1)), -1);
        chk("rand master_vol", int'(master_vol), m_master);
      end
      a = 8'($urandom()); b = 8'($urandom()); c = 8'($urandom());
      el = exp_audio(int'(a), int'(c), m_left);
      er = exp_audio(int'(b), int'(c), m_right);
      sample(a, b, c, "rand", gl, gr);
      if (gl != el || gr != er)
        $display("  inputs dl=%0d dr=%0d ym=%0d mix=%0d master=%0d left=%0d right=%0d",
                 a, b, c, m_mix, m_master, m_left, m_right);
      chk("rand L", gl, el);
      chk("rand R", gr, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
